// File: rtl/cordic_engine.sv
// ---------------------------------------------------------------------------
// cordic_engine
//
// Fully pipelined CORDIC engine supporting rotation and vectoring modes on a
// per-sample basis. One sample is accepted per enabled clock; results appear
// STAGES+2 enabled cycles after capture. The CORDIC gain K (~1.64676) is left
// uncompensated.
//
// Parameters
//   WIDTH  : signed data/angle width (Q2.(WIDTH-2), 1.0 = 2^(WIDTH-2))
//   STAGES : number of micro-rotation stages
//   GUARD  : extra MSBs carried on the x/y datapath
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset, wins over en
//   en         : pipeline enable, 0 freezes every register
//   in_valid   : qualifies x_in/y_in/z_in/mode
//   mode       : 0 = rotation, 1 = vectoring
//   x_in, y_in : input vector
//   z_in       : input angle in radians
//   out_valid  : qualifies the outputs
//   x_out, y_out, z_out : saturated results (0 when out_valid = 0)
//   range_err  : sample was outside the convergence region
// ---------------------------------------------------------------------------
module cordic_engine #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 16,
   parameter int GUARD  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic                    mode,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] z_in,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] x_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic signed [WIDTH-1:0] z_out,
   output logic                    range_err
);

   localparam int XW = WIDTH + GUARD;
   localparam int ZW = WIDTH + 1;
   // Fraction bits used by the elaboration-time constant arithmetic
   localparam int FB = 96;

   // atan(1/n) scaled by 2^FB, from its Taylor series in exact integers.
   // Only ever evaluated at elaboration time.
   function automatic logic [159:0] atanRecip(input logic [159:0] n);
      logic [159:0] one;
      logic [159:0] pw;
      logic [159:0] term;
      logic [159:0] acc;
      one = 160'd1 << FB;
      pw  = n;
      acc = '0;
      for (int k = 0; k < 64; k++) begin
         if (pw <= one) begin
            term = (one / pw) / 160'(2 * k + 1);
            if ((k % 2) == 0) acc = acc + term;
            else              acc = acc - term;
            pw = pw * n * n;
         end
      end
      return acc;
   endfunction

   // atan(2^-i) in z format, rounded to nearest. Stage 0 uses Machin's
   // formula because the plain series converges too slowly at 1.
   function automatic logic [ZW-1:0] atanConst(input int i);
      logic [159:0] v;
      if (i == 0) v = (atanRecip(160'd5) << 2) - atanRecip(160'd239);
      else        v = atanRecip(160'd1 << i);
      v = (v + (160'd1 << (FB - WIDTH + 1))) >> (FB - WIDTH + 2);
      return v[ZW-1:0];
   endfunction

   // floor(pi/2) in z format; any z strictly above this code exceeds pi/2
   function automatic logic [WIDTH-1:0] halfPiFloor();
      logic [159:0] v;
      v = (atanRecip(160'd5) << 3) - (atanRecip(160'd239) << 1);
      v = v >> (FB - WIDTH + 2);
      return v[WIDTH-1:0];
   endfunction

   // Clamp an extended-width value into the signed WIDTH-bit output range
   function automatic logic signed [WIDTH-1:0] satToWidth(input logic signed [XW-1:0] v);
      logic [GUARD:0] top;
      top = v[XW-1:WIDTH-1];
      if (top == '0 || top == '1) return v[WIDTH-1:0];
      else if (v[XW-1])           return {1'b1, {(WIDTH-1){1'b0}}};
      else                        return {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   localparam logic signed [WIDTH-1:0] HALF_PI     = halfPiFloor();
   localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI;

   // Index 0 is the input register, index i+1 holds the result of stage i
   logic                 r_valid [0:STAGES];
   logic                 r_mode  [0:STAGES];
   logic                 r_err   [0:STAGES];
   logic signed [XW-1:0] r_x     [0:STAGES];
   logic signed [XW-1:0] r_y     [0:STAGES];
   logic signed [ZW-1:0] r_z     [0:STAGES];

   logic signed [ZW-1:0] w_atan  [0:STAGES-1];
   logic                 w_dPos  [0:STAGES-1];
   logic signed [XW-1:0] w_xNext [0:STAGES-1];
   logic signed [XW-1:0] w_yNext [0:STAGES-1];
   logic signed [ZW-1:0] w_zNext [0:STAGES-1];

   // Arctangent table: each entry is a per-stage constant wire
   for (genvar g = 0; g < STAGES; g++) begin : gAtan
      localparam logic [ZW-1:0] ATAN_G = atanConst(g);
      assign w_atan[g] = ATAN_G;
   end

   // Micro-rotation datapath. dPos selects d = +1; rotation steers z toward
   // zero, vectoring steers y toward zero.
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         w_dPos[i]  = r_mode[i] ? r_y[i][XW-1] : ~r_z[i][ZW-1];
         w_xNext[i] = w_dPos[i] ? (r_x[i] - (r_y[i] >>> i)) : (r_x[i] + (r_y[i] >>> i));
         w_yNext[i] = w_dPos[i] ? (r_y[i] + (r_x[i] >>> i)) : (r_y[i] - (r_x[i] >>> i));
         w_zNext[i] = w_dPos[i] ? (r_z[i] - w_atan[i])      : (r_z[i] + w_atan[i]);
      end
   end

   // Input register plus iteration registers. The range check is made once
   // at capture and then simply travels with the sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i <= STAGES; i++) begin
            r_valid[i] <= 1'b0;
            r_mode[i]  <= 1'b0;
            r_err[i]   <= 1'b0;
            r_x[i]     <= '0;
            r_y[i]     <= '0;
            r_z[i]     <= '0;
         end
      end else if (en) begin
         r_valid[0] <= in_valid;
         r_mode[0]  <= mode;
         r_err[0]   <= mode ? x_in[WIDTH-1] : ((z_in > HALF_PI) || (z_in < NEG_HALF_PI));
         r_x[0]     <= XW'(x_in);
         r_y[0]     <= XW'(y_in);
         r_z[0]     <= ZW'(z_in);
         for (int i = 0; i < STAGES; i++) begin
            r_valid[i+1] <= r_valid[i];
            r_mode[i+1]  <= r_mode[i];
            r_err[i+1]   <= r_err[i];
            r_x[i+1]     <= w_xNext[i];
            r_y[i+1]     <= w_yNext[i];
            r_z[i+1]     <= w_zNext[i];
         end
      end
   end

   // Output register: saturate valid results, force zeros for bubbles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         z_out     <= '0;
         range_err <= 1'b0;
      end else if (en) begin
         out_valid <= r_valid[STAGES];
         if (r_valid[STAGES]) begin
            x_out     <= satToWidth(r_x[STAGES]);
            y_out     <= satToWidth(r_y[STAGES]);
            z_out     <= satToWidth(XW'(r_z[STAGES]));
            range_err <= r_err[STAGES];
         end else begin
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            range_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cordic_engine.sv
// ---------------------------------------------------------------------------
// tb_cordic_engine
//
// Directed testbench for cordic_engine at WIDTH=16, STAGES=16, GUARD=2.
// Expected values are hand-computed references with tolerances.
// ---------------------------------------------------------------------------
module tb_cordic_engine;

   localparam int WIDTH  = 16;
   localparam int STAGES = 16;
   localparam int GUARD  = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    en;
   logic                    in_valid;
   logic                    mode;
   logic signed [WIDTH-1:0] x_in;
   logic signed [WIDTH-1:0] y_in;
   logic signed [WIDTH-1:0] z_in;
   logic                    out_valid;
   logic signed [WIDTH-1:0] x_out;
   logic signed [WIDTH-1:0] y_out;
   logic signed [WIDTH-1:0] z_out;
   logic                    range_err;

   int checks = 0;
   int errors = 0;

   cordic_engine #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .GUARD (GUARD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (in_valid),
      .mode     (mode),
      .x_in     (x_in),
      .y_in     (y_in),
      .z_in     (z_in),
      .out_valid(out_valid),
      .x_out    (x_out),
      .y_out    (y_out),
      .z_out    (z_out),
      .range_err(range_err)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic m,
                                input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z);
      in_valid = v;
      mode     = m;
      x_in     = x;
      y_in     = y;
      z_in     = z;
   endtask

   // Reset clears everything; in_valid during reset is never captured
   task automatic test_reset();
      int stray;
      rst_n = 1'b0;
      en    = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h26DD, 16'h0000, 16'h3244);
      step();
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
      end
      checks++;
      if ({x_out, y_out, z_out, range_err} !== 49'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got x=%h y=%h z=%h err=%b want all 0", x_out, y_out, z_out, range_err);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      rst_n = 1'b1;
      stray = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (out_valid === 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("[TB] FAIL reset_ignored_sample: got %0d valid outputs want 0", stray);
      end
   endtask

   // Rotate (1/K, 0) by pi/4, also checks exact latency and bubble zeroing
   task automatic test_rotation_45();
      applyStimulus(1'b1, 1'b0, 16'h26DD, 16'h0000, 16'h3244);
      step();
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      repeat (16) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rot45_early_valid: got %b want 0 after 17 cycles", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rot45_valid: got %b want 1 after 18 cycles", out_valid);
      end
      checks++;
      if ((int'(x_out) - 11585) > 4 || (11585 - int'(x_out)) > 4) begin
         errors++;
         $display("[TB] FAIL rot45_x: got %0d want 11585 +/- 4", x_out);
      end
      checks++;
      if ((int'(y_out) - 11585) > 4 || (11585 - int'(y_out)) > 4) begin
         errors++;
         $display("[TB] FAIL rot45_y: got %0d want 11585 +/- 4", y_out);
      end
      checks++;
      if (int'(z_out) > 4 || int'(z_out) < -4) begin
         errors++;
         $display("[TB] FAIL rot45_z: got %0d want 0 +/- 4", z_out);
      end
      checks++;
      if (range_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rot45_err: got %b want 0", range_err);
      end
      step();
      checks++;
      if ({out_valid, x_out, y_out, z_out, range_err} !== 50'd0) begin
         errors++;
         $display("[TB] FAIL rot45_bubble: got v=%b x=%h y=%h z=%h want all 0", out_valid, x_out, y_out, z_out);
      end
   endtask

   // Rotation by zero angle just applies the gain
   task automatic test_rotation_zero();
      applyStimulus(1'b1, 1'b0, 16'h26DD, 16'h0000, 16'h0000);
      step();
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      repeat (17) step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rot0_valid: got %b want 1", out_valid);
      end
      checks++;
      if ((int'(x_out) - 16384) > 4 || (16384 - int'(x_out)) > 4) begin
         errors++;
         $display("[TB] FAIL rot0_x: got %0d want 16384 +/- 4", x_out);
      end
      checks++;
      if (int'(y_out) > 4 || int'(y_out) < -4) begin
         errors++;
         $display("[TB] FAIL rot0_y: got %0d want 0 +/- 4", y_out);
      end
   endtask

   // Vectoring of (0.75, 0.75): magnitude*K and angle pi/4
   task automatic test_vectoring();
      applyStimulus(1'b1, 1'b1, 16'h3000, 16'h3000, 16'h0000);
      step();
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      repeat (17) step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL vec_valid: got %b want 1", out_valid);
      end
      checks++;
      if ((int'(z_out) - 12868) > 4 || (12868 - int'(z_out)) > 4) begin
         errors++;
         $display("[TB] FAIL vec_z: got %0d want 12868 +/- 4", z_out);
      end
      checks++;
      if ((int'(x_out) - 28618) > 8 || (28618 - int'(x_out)) > 8) begin
         errors++;
         $display("[TB] FAIL vec_x: got %0d want 28618 +/- 8", x_out);
      end
      checks++;
      if (int'(y_out) > 4 || int'(y_out) < -4) begin
         errors++;
         $display("[TB] FAIL vec_y: got %0d want 0 +/- 4", y_out);
      end
      checks++;
      if (range_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL vec_err: got %b want 0", range_err);
      end
   endtask

   // Results beyond the output range clamp instead of wrapping
   task automatic test_saturation();
      applyStimulus(1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 16'h0000);
      step();
      applyStimulus(1'b1, 1'b0, 16'h8000, 16'h8000, 16'h0000);
      step();
      applyStimulus(1'b1, 1'b1, 16'h3000, 16'h3000, 16'h7FFF);
      step();
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      repeat (15) step();
      checks++;
      if ({out_valid, x_out, y_out} !== {1'b1, 16'h7FFF, 16'h7FFF}) begin
         errors++;
         $display("[TB] FAIL sat_pos: got v=%b x=%h y=%h want 1 7fff 7fff", out_valid, x_out, y_out);
      end
      step();
      checks++;
      if ({out_valid, x_out, y_out} !== {1'b1, 16'h8000, 16'h8000}) begin
         errors++;
         $display("[TB] FAIL sat_neg: got v=%b x=%h y=%h want 1 8000 8000", out_valid, x_out, y_out);
      end
      step();
      checks++;
      if ({out_valid, z_out, range_err} !== {1'b1, 16'h7FFF, 1'b0}) begin
         errors++;
         $display("[TB] FAIL sat_z: got v=%b z=%h err=%b want 1 7fff 0", out_valid, z_out, range_err);
      end
   endtask

   // Out-of-convergence flagging, including exact pi/2 and x sign boundaries
   task automatic test_range_err();
      logic [15:0] sx [8];
      logic [15:0] sy [8];
      logic [15:0] sz [8];
      logic        sm [8];
      logic        se [8];
      sx[0] = 16'h26DD; sy[0] = 16'h0000; sz[0] = 16'h7000; sm[0] = 1'b0; se[0] = 1'b1;
      sx[1] = 16'hC000; sy[1] = 16'h0000; sz[1] = 16'h0000; sm[1] = 1'b1; se[1] = 1'b1;
      sx[2] = 16'h26DD; sy[2] = 16'h0000; sz[2] = 16'h6487; sm[2] = 1'b0; se[2] = 1'b0;
      sx[3] = 16'h26DD; sy[3] = 16'h0000; sz[3] = 16'h6488; sm[3] = 1'b0; se[3] = 1'b1;
      sx[4] = 16'h26DD; sy[4] = 16'h0000; sz[4] = 16'h9B79; sm[4] = 1'b0; se[4] = 1'b0;
      sx[5] = 16'h26DD; sy[5] = 16'h0000; sz[5] = 16'h9B78; sm[5] = 1'b0; se[5] = 1'b1;
      sx[6] = 16'h0000; sy[6] = 16'h3000; sz[6] = 16'h0000; sm[6] = 1'b1; se[6] = 1'b0;
      sx[7] = 16'hFFFF; sy[7] = 16'h3000; sz[7] = 16'h0000; sm[7] = 1'b1; se[7] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, sm[k], sx[k], sy[k], sz[k]);
         step();
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      repeat (9) step();
      for (int k = 0; k < 8; k++) begin
         step();
         checks++;
         if ({out_valid, range_err} !== {1'b1, se[k]}) begin
            errors++;
            $display("[TB] FAIL range_err_%0d: got v=%b err=%b want v=1 err=%b", k, out_valid, range_err, se[k]);
         end
         if (k == 0) begin
            checks++;
            if ((int'(y_out) - 16141) > 32 || (16141 - int'(y_out)) > 32 ||
                (int'(x_out) + 2813) > 32 || (-2813 - int'(x_out)) > 32) begin
               errors++;
               $display("[TB] FAIL range_rot_xy: got x=%0d y=%0d want -2813 16141 +/- 32", x_out, y_out);
            end
            checks++;
            if ((int'(z_out) - 111) > 16 || (111 - int'(z_out)) > 16) begin
               errors++;
               $display("[TB] FAIL range_rot_z: got %0d want 111 +/- 16", z_out);
            end
         end
         if (k == 1) begin
            checks++;
            if ((int'(y_out) - 26581) > 64 || (26581 - int'(y_out)) > 64 ||
                (int'(x_out) - 4631) > 64 || (4631 - int'(x_out)) > 64) begin
               errors++;
               $display("[TB] FAIL range_vec_xy: got x=%0d y=%0d want 4631 26581 +/- 64", x_out, y_out);
            end
            checks++;
            if ((int'(z_out) - 28561) > 16 || (28561 - int'(z_out)) > 16) begin
               errors++;
               $display("[TB] FAIL range_vec_z: got %0d want 28561 +/- 16", z_out);
            end
         end
      end
   endtask

   // en=0 holds outputs and ignores in_valid
   task automatic test_enable_hold();
      int stray;
      en = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h26DD, 16'h0000, 16'h3244);
      step();
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      repeat (17) step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_pre_valid: got %b want 1", out_valid);
      end
      en = 1'b0;
      applyStimulus(1'b1, 1'b1, 16'h3000, 16'h3000, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || (int'(x_out) - 11585) > 4 || (11585 - int'(x_out)) > 4) begin
            errors++;
            $display("[TB] FAIL hold_frozen_%0d: got v=%b x=%0d want v=1 x=11585 +/- 4", k, out_valid, x_out);
         end
      end
      en = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      step();
      checks++;
      if ({out_valid, x_out, y_out, z_out} !== 49'd0) begin
         errors++;
         $display("[TB] FAIL hold_release: got v=%b x=%h y=%h z=%h want all 0", out_valid, x_out, y_out, z_out);
      end
      stray = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (out_valid === 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("[TB] FAIL hold_ignored_sample: got %0d valid outputs want 0", stray);
      end
   endtask

   // 20 back-to-back mixed-mode samples with a 3-cycle freeze mid-stream
   task automatic test_back_to_back();
      int   sent;
      int   got;
      int   ex, ey, ez, tx, ty, tz;
      logic enNow;
      sent = 0;
      got  = 0;
      for (int c = 0; c < 60; c++) begin
         if (c >= 10 && c < 13) begin
            en = 1'b0;
            applyStimulus(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF);
         end else begin
            en = 1'b1;
            if (sent < 20) begin
               case (sent % 3)
                  0:       applyStimulus(1'b1, 1'b0, 16'h26DD, 16'h0000, 16'h3244);
                  1:       applyStimulus(1'b1, 1'b0, 16'h26DD, 16'h0000, 16'h0000);
                  default: applyStimulus(1'b1, 1'b1, 16'h3000, 16'h3000, 16'h0000);
               endcase
               sent++;
            end else begin
               applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
            end
         end
         enNow = en;
         step();
         if (enNow && out_valid === 1'b1) begin
            case (got % 3)
               0:       begin ex = 11585; ey = 11585; ez = 0;     tx = 4; ty = 4; tz = 4; end
               1:       begin ex = 16384; ey = 0;     ez = 0;     tx = 4; ty = 4; tz = 4; end
               default: begin ex = 28618; ey = 0;     ez = 12868; tx = 8; ty = 4; tz = 4; end
            endcase
            checks++;
            if (c + 1 != 21 + got) begin
               errors++;
               $display("[TB] FAIL b2b_timing_%0d: got edge %0d want edge %0d", got, c + 1, 21 + got);
            end
            checks++;
            if ((int'(x_out) - ex) > tx || (ex - int'(x_out)) > tx ||
                (int'(y_out) - ey) > ty || (ey - int'(y_out)) > ty ||
                (int'(z_out) - ez) > tz || (ez - int'(z_out)) > tz) begin
               errors++;
               $display("[TB] FAIL b2b_value_%0d: got x=%0d y=%0d z=%0d want %0d %0d %0d", got, x_out, y_out, z_out, ex, ey, ez);
            end
            got++;
         end
      end
      checks++;
      if (got != 20) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d results want 20", got);
      end
      en = 1'b1;
   endtask

   // One-cycle reset with a full pipeline flushes everything, even with en=0
   task automatic test_reset_flush();
      int stray;
      en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, 1'b0, 16'h26DD, 16'h0000, 16'h3244);
         step();
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_pre_valid: got %b want 1", out_valid);
      end
      rst_n = 1'b0;
      en    = 1'b0;
      step();
      checks++;
      if ({out_valid, x_out, y_out, z_out, range_err} !== 50'd0) begin
         errors++;
         $display("[TB] FAIL flush_reset: got v=%b x=%h y=%h z=%h err=%b want all 0", out_valid, x_out, y_out, z_out, range_err);
      end
      rst_n = 1'b1;
      en    = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      stray = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (out_valid === 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("[TB] FAIL flush_stale: got %0d valid outputs want 0", stray);
      end
   endtask

   // Test sequence
   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      test_reset();
      test_rotation_45();
      test_rotation_zero();
      test_vectoring();
      test_saturation();
      test_range_err();
      test_enable_hold();
      test_back_to_back();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a hung simulation
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/cordic_engine.md
CORDIC_ENGINE -- requirements
Module: cordic_engine

Interface
REQ-001 Parameter WIDTH, 16, signed data and angle width in bits; legal range 8..24.
REQ-002 Parameter STAGES, 16, number of CORDIC micro-rotation stages; legal range 4..WIDTH.
REQ-003 Parameter GUARD, 2, extra internal MSBs on the x/y datapath; legal range 1..4.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 en  input  1  pipeline enable; 0 freezes every stage register.
REQ-007 in_valid  input  1  sample qualifier for x_in/y_in/z_in/mode.
REQ-008 mode  input  1  0 = rotation, 1 = vectoring; carried per sample.
REQ-009 x_in, y_in  input  WIDTH each  signed Q2.(WIDTH-2) vector, 1.0 = 2^(WIDTH-2).
REQ-010 z_in  input  WIDTH  signed angle in radians, same format; pi/4 = 0x3244 at WIDTH=16.
REQ-011 out_valid  output  1  result qualifier.
REQ-012 x_out, y_out, z_out  output  WIDTH each  signed results, same formats as inputs.
REQ-013 range_err  output  1  out-of-convergence flag, qualified by out_valid.

Function
REQ-014 Structure: input register stage, then STAGES iteration stages, output register last; latency = STAGES+2 enabled cycles from an in_valid capture to out_valid.
REQ-015 Every stage carries valid, mode, range_err, x, y (WIDTH+GUARD bits, sign-extended) and z (WIDTH+1 bits).
REQ-016 Stage i (0..STAGES-1), direction d: rotation d = +1 if z >= 0, else -1; vectoring d = +1 if y < 0, else -1.
REQ-017 Stage i update: x' = x - d*(y >>> i), y' = y + d*(x >>> i), z' = z - d*atan_i; shifts arithmetic, truncating.
REQ-018 atan_i = atan(2^-i) in z format, rounded to nearest, computed as an elaboration-time constant table; no runtime table logic.
REQ-019 Rotation result: x_out ~ K*(x cos z - y sin z), y_out ~ K*(y cos z + x sin z), z_out ~ 0; K = 1.64676 is not compensated.
REQ-020 Vectoring result: x_out ~ K*sqrt(x^2+y^2), y_out ~ 0, z_out ~ z_in + atan(y_in/x_in).
REQ-021 Output stage saturates x, y, z to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap-around on any output.
REQ-022 range_err is set at the input stage when rotation has |z_in| > pi/2, or when vectoring has x_in < 0; the sample is still computed and emitted.
REQ-023 A bubble (in_valid=0) propagates as valid=0; data registers of bubble stages are don't-care, but outputs are held at 0 when out_valid=0.
REQ-024 en=0: no register changes, in_valid is ignored, and out_valid/outputs hold their last values; en=1 resumes with no sample lost or duplicated.
REQ-025 Full throughput: one sample accepted per enabled cycle, and back-to-back samples with mixed mode are processed independently.

Reset
REQ-026 rst_n=0 at a rising edge clears all valid bits, data, mode and range_err registers to 0, regardless of en.
REQ-027 During and after reset: out_valid=0, x_out=y_out=z_out=0, range_err=0; in-flight samples are discarded.
REQ-028 in_valid sampled in the reset cycle is ignored; the first capture occurs on the first edge with rst_n=1 and en=1.

Verification
REQ-029 Rotation, WIDTH=16, STAGES=16: x_in=0x26DD, y_in=0, z_in=0x3244 -> after 18 cycles out_valid=1, x_out~y_out~0x2D41 (+/-4 LSB), range_err=0.
REQ-030 Rotation: x_in=0x26DD, y_in=0, z_in=0 -> x_out~0x4000, y_out~0 (+/-4 LSB).
REQ-031 Vectoring: x_in=y_in=0x3000, z_in=0 -> z_out~0x3244 (+/-4 LSB), x_out~0x6FCA (+/-8 LSB), y_out~0 (+/-4 LSB).
REQ-032 Stream of 20 back-to-back mixed-mode samples with en=0 for 3 cycles mid-stream -> 20 results in order, values match REQ-029..031 references, and total latency is extended by exactly 3.
REQ-033 Full pipeline, then rst_n=0 for one cycle -> the next edge shows out_valid=0 with all outputs 0; no stale out_valid after release.
REQ-034 Rotation with z_in=0x7000, and vectoring with x_in=0xC000 -> each emerges with range_err=1, out_valid=1, and outputs saturated within range.
